// File: rtl/clk_mockup_strobe_gen.sv
// ----------------------------------------------------------------------------
// clk_mockup_strobe_gen
//   Testbench-side timing source for combinational DUVs.  One real clock is
//   turned into NUM_CH mock-clock channels, each with its own divide ratio and
//   start phase.  Per channel, drive_stb marks the mock posedge (drive
//   stimulus) and sample_stb marks the last real cycle of the mock period
//   (sample results).  A stretched mock reset is provided for bench parts.
//
//   Optional feature macro: MOCK_CLK_OUT_EN
//     defined   -> extra output mock_clk[NUM_CH], a registered square wave
//                  per channel (high while cnt < ceil(div/2)).
//     undefined -> port and its logic are absent.
//
// Ports
//   clk         in   testbench clock, all logic on posedge
//   rst         in   synchronous active-high reset
//   run         in   1: strobes advance, 0: pause (counters frozen)
//   cfg_valid   in   config request
//   cfg_ready   out  config accepted when cfg_valid & cfg_ready
//   cfg_ch      in   target channel (out-of-range channel accepted, ignored)
//   cfg_div     in   divide ratio, 0 treated as 1
//   cfg_phase   in   start offset, >= effective div treated as 0
//   rst_mock    out  stretched mock reset
//   drive_stb   out  per-channel 1-cycle pulse at mock posedge
//   sample_stb  out  per-channel 1-cycle pulse on last cycle of mock period
//   period_cnt  out  completed mock periods of channel 0 (wraps)
//   mock_clk    out  per-channel square wave (MOCK_CLK_OUT_EN only)
// ----------------------------------------------------------------------------

// Per-channel divider: config storage, phase reload and registered strobes.
module clk_mockup_strobe_ch #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv,      // RUN and run=1: counter steps this cycle
   input  logic             start,    // PAUSE -> RUN transition this cycle
`ifdef MOCK_CLK_OUT_EN
   input  logic             hold,     // top FSM is in HOLD
`endif
   input  logic             cfg_we,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [DIV_W-1:0] cfg_phase,
   output logic             drive_stb,
   output logic             sample_stb,
`ifdef MOCK_CLK_OUT_EN
   output logic             mock_clk,
`endif
   output logic             wrap      // sample_stb is being set on this edge
);

   localparam logic [DIV_W-1:0] DEF_DIV =
      (DEFAULT_DIV < 1) ? DIV_W'(1) : DIV_W'(DEFAULT_DIV);

   logic [DIV_W-1:0] div, phase, cnt;
   logic [DIV_W-1:0] new_div, new_phase;
   logic             reload;   // next PAUSE->RUN entry restarts cnt at phase
   logic             last;

   // Config is normalised once at write time so the counter never sees div=0
   // or a phase outside 0..div-1.
   assign new_div   = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
   assign new_phase = (cfg_phase >= new_div) ? '0 : cfg_phase;
   assign last      = (cnt == div - DIV_W'(1));
   assign wrap      = adv && last;

   always_ff @(posedge clk) begin
      if (rst) begin
         div        <= DEF_DIV;
         phase      <= '0;
         cnt        <= '0;
         reload     <= 1'b1;
         drive_stb  <= 1'b0;
         sample_stb <= 1'b0;
      end else begin
         if (cfg_we) begin
            div    <= new_div;
            phase  <= new_phase;
            reload <= 1'b1;
         end
         if (start) begin
            // A config landing on the same edge as run=1 takes effect now.
            if (cfg_we)
               cnt <= new_phase;
            else if (reload)
               cnt <= phase;
            reload <= 1'b0;
         end else if (adv) begin
            cnt <= last ? '0 : cnt + DIV_W'(1);
         end
         drive_stb  <= adv && (cnt == '0);
         sample_stb <= adv && last;
      end
   end

`ifdef MOCK_CLK_OUT_EN
   logic [DIV_W:0] half;
   assign half = ({1'b0, div} + (DIV_W+1)'(1)) >> 1;   // ceil(div/2)

   always_ff @(posedge clk) begin
      if (rst || hold)
         mock_clk <= 1'b0;
      else if (adv)
         mock_clk <= ({1'b0, cnt} < half);
      // PAUSE: hold last value
   end
`endif

endmodule

module clk_mockup_strobe_gen #(
   parameter  int NUM_CH      = 4,
   parameter  int DIV_W       = 8,
   parameter  int RST_HOLD    = 4,
   parameter  int DEFAULT_DIV = 2,
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [DIV_W-1:0]  cfg_phase,
   output logic              rst_mock,
   output logic [NUM_CH-1:0] drive_stb,
   output logic [NUM_CH-1:0] sample_stb,
`ifdef MOCK_CLK_OUT_EN
   output logic [NUM_CH-1:0] mock_clk,
`endif
   output logic [31:0]       period_cnt
);

   localparam int HC_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

   typedef enum logic [1:0] {S_HOLD, S_PAUSE, S_RUN} state_t;

   state_t            state, state_nxt;
   logic [HC_W-1:0]   hold_cnt, hold_cnt_nxt;
   logic              cfg_fire, start, adv;
   logic [NUM_CH-1:0] cfg_we, wrap;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_HOLD;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      case (state)
         S_HOLD: begin
            if (hold_cnt == HC_W'(RST_HOLD - 1))
               state_nxt = S_PAUSE;
            else
               hold_cnt_nxt = hold_cnt + HC_W'(1);
         end
         S_PAUSE: if (run)  state_nxt = S_RUN;
         S_RUN:   if (!run) state_nxt = S_PAUSE;
         default:           state_nxt = S_HOLD;
      endcase
   end

   // Mock reset follows HOLD, so it drops the cycle after hold_cnt completes.
   assign rst_mock  = (state == S_HOLD);
   assign cfg_ready = !rst && (state != S_RUN);
   assign cfg_fire  = cfg_valid && cfg_ready;
   assign start     = (state == S_PAUSE) && run;
   assign adv       = (state == S_RUN) && run;

   // ---------------- channels ----------------
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      // Out-of-range cfg_ch matches no channel: accepted but dropped.
      assign cfg_we[g] = cfg_fire && (cfg_ch == CH_W'(g));

      clk_mockup_strobe_ch #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .adv        (adv),
         .start      (start),
`ifdef MOCK_CLK_OUT_EN
         .hold       (state == S_HOLD),
`endif
         .cfg_we     (cfg_we[g]),
         .cfg_div    (cfg_div),
         .cfg_phase  (cfg_phase),
         .drive_stb  (drive_stb[g]),
         .sample_stb (sample_stb[g]),
`ifdef MOCK_CLK_OUT_EN
         .mock_clk   (mock_clk[g]),
`endif
         .wrap       (wrap[g])
      );
   end

   // Counts on the same edge that raises sample_stb[0], so the new count is
   // visible alongside the strobe.
   always_ff @(posedge clk) begin
      if (rst)
         period_cnt <= '0;
      else if (wrap[0])
         period_cnt <= period_cnt + 32'd1;
   end

endmodule

// File: tb/tb_clk_mockup_strobe_gen.sv
module tb_clk_mockup_strobe_gen;

   localparam int NUM_CH = 4;
   localparam int DIV_W  = 8;

   localparam int S_RM  = 0;
   localparam int S_DRV = 1;
   localparam int S_SMP = 2;
   localparam int S_PC  = 3;
   localparam int S_RDY = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              run = 1'b0;
   logic              cfg_valid = 1'b0;
   logic              cfg_ready;
   logic [1:0]        cfg_ch = '0;
   logic [DIV_W-1:0]  cfg_div = '0;
   logic [DIV_W-1:0]  cfg_phase = '0;
   logic              rst_mock;
   logic [NUM_CH-1:0] drive_stb, sample_stb;
   logic [31:0]       period_cnt;
`ifdef MOCK_CLK_OUT_EN
   logic [NUM_CH-1:0] mock_clk;
`endif

   clk_mockup_strobe_gen #(
      .NUM_CH(NUM_CH), .DIV_W(DIV_W), .RST_HOLD(4), .DEFAULT_DIV(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_div    (cfg_div),
      .cfg_phase  (cfg_phase),
      .rst_mock   (rst_mock),
      .drive_stb  (drive_stb),
      .sample_stb (sample_stb),
`ifdef MOCK_CLK_OUT_EN
      .mock_clk   (mock_clk),
`endif
      .period_cnt (period_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          at;
      int          sel;
      logic [31:0] val;
      string       name;
   } chk_t;

   chk_t q[$];
   int   total  = 0;
   int   passed = 0;

   task automatic expect_at(input int at, input int sel, input logic [31:0] val,
                            input string nm);
      chk_t c;
      c.at = at; c.sel = sel; c.val = val; c.name = nm;
      q.push_back(c);
   endtask

   function automatic logic [31:0] pick(input int sel);
      case (sel)
         S_RM:    return {31'd0, rst_mock};
         S_DRV:   return {28'd0, drive_stb};
         S_SMP:   return {28'd0, sample_stb};
         S_PC:    return period_cnt;
         default: return {31'd0, cfg_ready};
      endcase
   endfunction

   // Monitor: on each negedge, retire every expectation due this cycle.
   always @(negedge clk) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].at <= cyc) begin
            logic [31:0] act;
            act = pick(q[i].sel);
            total++;
            if (q[i].at == cyc && act === q[i].val)
               passed++;
            else
               $display("FAIL %s @cyc %0d (due %0d): got %h want %h",
                        q[i].name, cyc, q[i].at, act, q[i].val);
            q.delete(i);
         end
      end
   end

   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobes(input int at, input logic [3:0] d, input logic [3:0] s,
                          input int pc);
      expect_at(at, S_DRV, {28'd0, d}, "drive_stb");
      expect_at(at, S_SMP, {28'd0, s}, "sample_stb");
      expect_at(at, S_PC,  pc,         "period_cnt");
   endtask

   // RUN window after first start: ch0 div2, ch1 div5 ph2, ch2 div1, ch3 div4
   logic [3:0] d1 [9] = '{4'b1101, 4'b0100, 4'b0101, 4'b0110, 4'b1101,
                          4'b0100, 4'b0101, 4'b0100, 4'b1111};
   logic [3:0] s1 [9] = '{4'b0100, 4'b0101, 4'b0110, 4'b1101, 4'b0100,
                          4'b0101, 4'b0100, 4'b1111, 4'b0100};
   int         p1 [9] = '{0, 1, 1, 2, 2, 3, 3, 4, 4};
   // RUN window after resume: ch0 now div3 ph1, others resume frozen counts
   logic [3:0] d2 [8] = '{4'b0100, 4'b0100, 4'b0101, 4'b1100, 4'b0110,
                          4'b0101, 4'b0100, 4'b1100};
   logic [3:0] s2 [8] = '{4'b0100, 4'b0101, 4'b1100, 4'b0110, 4'b0101,
                          4'b0100, 4'b1100, 4'b0101};
   int         p2 [8] = '{4, 5, 5, 5, 6, 6, 6, 7};

   initial begin
      // reset held for edges 1..3
      goto(3);
      expect_at(3, S_RM, 1, "reset rst_mock");
      strobes(3, 4'b0000, 4'b0000, 0);
      expect_at(3, S_RDY, 0, "reset cfg_ready");
      goto(4);
      rst = 1'b0;
      for (int c = 4; c < 8; c++) expect_at(c, S_RM, 1, "hold rst_mock");
      expect_at(8, S_RM, 0, "hold release");
      expect_at(4, S_RDY, 1, "hold cfg_ready");

      // configs during HOLD: ch2 div=0 -> 1; ch3 div=4 phase=9 -> 0
      goto(5);
      cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0; cfg_phase = 8'd0;
      goto(6);
      cfg_ch = 2'd3; cfg_div = 8'd4; cfg_phase = 8'd9;
      goto(7);
      cfg_valid = 1'b0;
      expect_at(8, S_RDY, 1, "pause cfg_ready");
      strobes(8, 4'b0000, 4'b0000, 0);

      // simultaneous run=1 and config ch1 div=5 phase=2
      goto(8);
      cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5; cfg_phase = 8'd2;
      run = 1'b1;
      expect_at(9, S_RDY, 0, "run cfg_ready");
      strobes(9, 4'b0000, 4'b0000, 0);
      goto(9);
      cfg_valid = 1'b0;
      for (int k = 0; k < 9; k++) strobes(10 + k, d1[k], s1[k], p1[k]);

      // config while running is held off until PAUSE
      goto(16);
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3; cfg_phase = 8'd1;
      for (int c = 16; c < 19; c++) expect_at(c, S_RDY, 0, "run holds cfg");
      goto(18);
      run = 1'b0;
      strobes(19, 4'b0000, 4'b0000, 4);
      expect_at(19, S_RDY, 1, "pause accepts cfg");
      goto(20);
      cfg_valid = 1'b0;
      run = 1'b1;
      strobes(21, 4'b0000, 4'b0000, 4);
      expect_at(21, S_RDY, 0, "resume cfg_ready");
      for (int k = 0; k < 8; k++) strobes(22 + k, d2[k], s2[k], p2[k]);

      // rst mid-RUN with period_cnt=7, colliding config is dropped
      goto(29);
      rst = 1'b1;
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd7; cfg_phase = 8'd0;
      strobes(30, 4'b0000, 4'b0000, 0);
      expect_at(30, S_RM, 1, "midrun rst_mock");
      goto(30);
      rst = 1'b0;
      cfg_valid = 1'b0;
      expect_at(30, S_RDY, 1, "rehold cfg_ready");
      for (int c = 31; c < 34; c++) expect_at(c, S_RM, 1, "rehold rst_mock");
      expect_at(34, S_RM, 0, "rehold release");
      strobes(35, 4'b0000, 4'b0000, 0);
      strobes(36, 4'b1111, 4'b0000, 0);
      strobes(37, 4'b0000, 4'b1111, 1);
      strobes(38, 4'b1111, 4'b0000, 1);

      // drain scoreboard with a bounded wait
      for (int w = 0; w < 20 && q.size() != 0; w++) goto(cyc + 1);
      @(posedge clk); #1;
      if (q.size() != 0) begin
         total++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
